terrain_gen: RTL and testbench
==============================

Name: terrain_gen

Overview:
- Produces the 3-bit `lines` platform pattern that move_player consumes, and owns the game-run lifecycle.
- Scrolls procedurally generated platform segments past the player column.
- Reads the player's `height` back from move_player and asserts `is_dead` when the player leaves the playfield.
- Sits between the game top level (start button) and move_player.

Parameters:
- SCROLL_DIV, 4, clocks per column step (>=1)
- SEG_BASE, 8, minimum segment length in columns; also the length of the first safe segment (>=1)
- SEED, 16'hACE1, LFSR reset value (nonzero)
- DEATH_LO, 9'd10, `height` strictly below this = dead
- DEATH_HI, 9'd470, `height` strictly above this = dead

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; begins or restarts a run
- height  in  9  player height from move_player
- lines  out  3  platform pattern at the player column, to move_player
- is_dead  out  1  run-over flag, to move_player
- score  out  16  columns survived in the current run
- seg_start  out  1  one-clock pulse when a new segment's pattern takes effect

Behaviour:
- Reset (synchronous, active-high) on clk rising edge, from any state including mid-run:
  - state=IDLE, lines=3'b111, is_dead=0, score=0, seg_start=0
  - lfsr=SEED, div_cnt=0, seg_left=SEG_BASE
- States:
  - IDLE: lines=111, no scrolling; start=1 -> RUN at next edge.
  - RUN: scrolling active.
  - DEAD: is_dead=1, lines=000, score frozen.
- Entering RUN (from IDLE or DEAD):
  - lines=111, seg_left=SEG_BASE, div_cnt=0, score=0, is_dead=0.
  - LFSR is not reseeded on restart.
- Column tick:
  - In RUN, div_cnt counts 0..SCROLL_DIV-1; tick = (div_cnt==SCROLL_DIV-1), after which div_cnt wraps to 0.
  - SCROLL_DIV=1 means a tick every clock.
- On each tick:
  - score increments, saturating at 16'hFFFF.
  - LFSR advances one step: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, new bit0 = b15^b13^b12^b10.
  - If seg_left>1: seg_left decrements.
- On a tick with seg_left==1, the next segment is computed from the pre-advance lfsr value:
  - c = lfsr[2:0]; if c==000 then c=111
  - if (c & lines)==000 then c = c | lines (guarantees a shared platform, so the run is always survivable)
  - lines<=c, seg_left<=SEG_BASE + lfsr[6:3] (range SEG_BASE..SEG_BASE+15), seg_start=1 for that one clock
  - c equal to the current lines is legal; seg_start still pulses.
- Death check:
  - Evaluated every clock in RUN: (height<DEATH_LO) or (height>DEATH_HI) -> DEAD at next edge.
  - On entry to DEAD: is_dead=1, lines=000, seg_start=0.
  - Death has priority over a simultaneous tick or segment boundary: score, lines and LFSR do not update that cycle.
  - height exactly equal to DEATH_LO or DEATH_HI is alive.
- DEAD: start=1 -> RUN (restart as above). Otherwise hold.
- start is ignored while in RUN.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency from start to the first tick is SCROLL_DIV clocks after RUN entry.
- Widths:
  - score is 16 bits unsigned.
  - seg_left is 5 bits (SEG_BASE+15 must fit; the bench checks SEG_BASE<=16).

Test Plan:
- Reset then idle: rst=1 for 2 clk, start=0, height=200 for 50 clk -> lines=111, is_dead=0, score=0, seg_start never 1.
- First segment (SCROLL_DIV=2, SEG_BASE=8): start=1 for one clk, height=200 -> lines stays 111 for exactly 16 clk after RUN entry.
  - Then seg_start pulses once.
  - New lines equals the rule applied to lfsr at that tick (reference model), and is never 000.
- Survivability: run 10000 clk with height=200 -> every transition has (new & old)!=0, seg lengths are in 8..23 columns, and score equals ticks counted.
- Death boundary: height=10 -> alive. height=9 for one clk -> next edge is_dead=1, lines=000, score frozen. Repeat with 470 (alive) and 471 (dead).
- Death vs boundary: drive height=471 on the same clock as the seg_left==1 tick -> is_dead=1, lines=000, no seg_start, score not incremented.
- Restart and mid-run reset:
  - From DEAD, start=1 -> lines=111, score=0, is_dead=0, and the LFSR continues (differs from SEED).
  - rst=1 mid-RUN -> IDLE, lfsr=SEED, all outputs at reset values the next clock.
- Saturation: force score to 16'hFFFE, allow 3 ticks -> score=16'hFFFF and holds.

Source files
------------

// File: rtl/terrain_gen.sv
// Platform scroller and run-lifecycle controller: generates the 3-bit lines pattern
// from an LFSR, counts survived columns and flags death when height leaves the playfield.
module terrain_gen #(
  parameter int          SCROLL_DIV = 4,
  parameter int          SEG_BASE   = 8,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [8:0]  DEATH_LO   = 9'd10,
  parameter logic [8:0]  DEATH_HI   = 9'd470
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  height,
  output logic [2:0]  lines,
  output logic        is_dead,
  output logic [15:0] score,
  output logic        seg_start
);

  localparam int             DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [4:0]     SEG_INIT = 5'(SEG_BASE);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       lines_reg, lines_next;
  logic             is_dead_reg, is_dead_next;
  logic [15:0]      score_reg, score_next;
  logic             seg_start_reg, seg_start_next;
  logic [15:0]      lfsr_reg, lfsr_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [4:0]       seg_left_reg, seg_left_next;

  logic       tick;
  logic       out_of_field;
  logic       enter_run;
  logic [2:0] new_pattern;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      lines_reg     <= 3'b111;
      is_dead_reg   <= 1'b0;
      score_reg     <= 16'd0;
      seg_start_reg <= 1'b0;
      lfsr_reg      <= SEED;
      div_cnt_reg   <= '0;
      seg_left_reg  <= SEG_INIT;
    end else begin
      state_reg     <= state_next;
      lines_reg     <= lines_next;
      is_dead_reg   <= is_dead_next;
      score_reg     <= score_next;
      seg_start_reg <= seg_start_next;
      lfsr_reg      <= lfsr_next;
      div_cnt_reg   <= div_cnt_next;
      seg_left_reg  <= seg_left_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lines_next     = lines_reg;
    is_dead_next   = is_dead_reg;
    score_next     = score_reg;
    seg_start_next = 1'b0;
    lfsr_next      = lfsr_reg;
    div_cnt_next   = div_cnt_reg;
    seg_left_next  = seg_left_reg;
    enter_run      = 1'b0;

    tick         = (div_cnt_reg == DIV_LAST);
    out_of_field = (height < DEATH_LO) || (height > DEATH_HI);

    // Next pattern always shares a platform with the current one, so every run is survivable
    new_pattern = (lfsr_reg[2:0] == 3'b000) ? 3'b111 : lfsr_reg[2:0];
    if ((new_pattern & lines_reg) == 3'b000)
      new_pattern = new_pattern | lines_reg;

    case (state_reg)
      IDLE: begin
        lines_next = 3'b111;
        if (start)
          enter_run = 1'b1;
      end
      RUN: begin
        if (out_of_field) begin
          // Death wins over any same-cycle tick: score, lines and LFSR stay put
          state_next   = DEAD;
          is_dead_next = 1'b1;
          lines_next   = 3'b000;
        end else if (tick) begin
          div_cnt_next = '0;
          if (score_reg != 16'hFFFF)
            score_next = score_reg + 16'd1;
          lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
          if (seg_left_reg > 5'd1) begin
            seg_left_next = seg_left_reg - 5'd1;
          end else begin
            lines_next     = new_pattern;
            seg_left_next  = SEG_INIT + {1'b0, lfsr_reg[6:3]};
            seg_start_next = 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      DEAD: begin
        if (start)
          enter_run = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (enter_run) begin
      state_next    = RUN;
      lines_next    = 3'b111;
      seg_left_next = SEG_INIT;
      div_cnt_next  = '0;
      score_next    = 16'd0;
      is_dead_next  = 1'b0;
    end
  end

  assign lines     = lines_reg;
  assign is_dead   = is_dead_reg;
  assign score     = score_reg;
  assign seg_start = seg_start_reg;

endmodule

// File: tb/tb_terrain_gen.sv
// Scoreboard bench for terrain_gen: directed stimulus queues expected outputs by cycle,
// a negedge monitor pops/compares them and checks every segment change against the LFSR rule.
module tb_terrain_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  height = 9'd200;
  logic [2:0]  lines;
  logic        is_dead;
  logic [15:0] score;
  logic        seg_start;

  logic        rst2 = 1'b1;
  logic        start2 = 1'b0;
  logic [8:0]  height2 = 9'd200;
  logic [2:0]  lines2;
  logic        is_dead2;
  logic [15:0] score2;
  logic        seg_start2;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  terrain_gen #(
    .SCROLL_DIV(2), .SEG_BASE(8), .SEED(16'hACE1), .DEATH_LO(9'd10), .DEATH_HI(9'd470)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .height(height),
    .lines(lines), .is_dead(is_dead), .score(score), .seg_start(seg_start)
  );

  // Free-running instance at one tick per clock, used only to reach score saturation
  terrain_gen #(
    .SCROLL_DIV(1), .SEG_BASE(8), .SEED(16'hACE1), .DEATH_LO(9'd10), .DEATH_HI(9'd470)
  ) dut_sat (
    .clk(clk), .rst(rst2), .start(start2), .height(height2),
    .lines(lines2), .is_dead(is_dead2), .score(score2), .seg_start(seg_start2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          at;
    logic [2:0]  lines;
    bit          chk_lines;
    logic        dead;
    logic [15:0] score;
    logic        seg;
    bit          chk_seg;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  function automatic void chk(string nm, bit ok, string msg);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", nm, msg);
    end else begin
      $display("[TB] ok %s: %s", nm, msg);
    end
  endfunction

  function automatic void push(int at, string nm, logic [2:0] l, bit cl,
                               logic d, logic [15:0] s, logic sg, bit cs);
    exp_t x;
    x.at = at; x.lines = l; x.chk_lines = cl; x.dead = d;
    x.score = s; x.seg = sg; x.chk_seg = cs;
    sb.push_back(x);
    sb_name.push_back(nm);
  endfunction

  // Monitor / reference model state
  logic [15:0] m_lfsr = 16'hACE1;
  logic [2:0]  prev_lines = 3'b111;
  logic [15:0] prev_score = 16'd0;
  logic [15:0] last_seg_score = 16'd0;
  int          exp_len = 8;
  int          seg_pulses = 0;

  always @(negedge clk) begin
    exp_t       x;
    string      nm;
    logic [2:0] c;
    bit         ok;
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      x  = sb.pop_front();
      nm = sb_name.pop_front();
      ok = (x.at == cyc) && (is_dead === x.dead) && (score === x.score) &&
           (!x.chk_lines || lines === x.lines) && (!x.chk_seg || seg_start === x.seg);
      chk(nm, ok, $sformatf("cyc=%0d (due %0d) lines=%b req %b dead=%b req %b score=%h req %h seg=%b req %b",
          cyc, x.at, lines, x.lines, is_dead, x.dead, score, x.score, seg_start, x.seg));
    end
    if (score == 16'd0) begin
      last_seg_score = 16'd0;
      exp_len = 8;
    end
    if (score == prev_score + 16'd1 && is_dead === 1'b0) begin
      // A column tick happened on the last edge
      if (seg_start === 1'b1) begin
        seg_pulses++;
        c = (m_lfsr[2:0] == 3'b000) ? 3'b111 : m_lfsr[2:0];
        if ((c & prev_lines) == 3'b000) c = c | prev_lines;
        chk("seg_rule", lines === c && lines != 3'b000 && (lines & prev_lines) != 3'b000,
            $sformatf("cyc=%0d lines=%b req %b old=%b lfsr=%h", cyc, lines, c, prev_lines, m_lfsr));
        chk("seg_len", int'(score - last_seg_score) == exp_len && exp_len >= 8 && exp_len <= 23,
            $sformatf("cyc=%0d columns=%0d req %0d", cyc, int'(score - last_seg_score), exp_len));
        last_seg_score = score;
        exp_len = 8 + int'(m_lfsr[6:3]);
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end else if (seg_start === 1'b1) begin
      seg_pulses++;
      chk("seg_needs_tick", 1'b0, $sformatf("cyc=%0d seg_start=1 req 0 (no tick)", cyc));
    end
    if (rst) m_lfsr = 16'hACE1;
    prev_lines = lines;
    prev_score = score;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outputs through the first segment after a fresh-seed RUN entry at cycle e:
  // SEED ACE1 advanced 7 times gives 70F2 -> lines 010, next segment 8+14=22 columns.
  task automatic push_first_seg(int e, string tag);
    for (int k = 0; k < 18; k++)
      push(e + k, tag, (k < 16) ? 3'b111 : 3'b010, 1'b1, 1'b0, 16'(k / 2), (k == 16), 1'b1);
    push(e + 59, {tag, "_seg2_pre"}, 3'b000, 1'b0, 1'b0, 16'd29, 1'b0, 1'b1);
    push(e + 60, {tag, "_seg2_len22"}, 3'b000, 1'b0, 1'b0, 16'd30, 1'b1, 1'b1);
  endtask

  initial begin
    int e;
    int v;
    int g;
    step(2);
    rst = 1'b0; rst2 = 1'b0; start2 = 1'b1;

    // Idle after reset
    push(cyc + 1, "idle_a", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    push(cyc + 25, "idle_b", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    push(cyc + 50, "idle_c", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(50);
    chk("idle_no_seg", seg_pulses == 0, $sformatf("seg pulses=%0d req 0", seg_pulses));

    // First segment from seed, then long survivability run
    start = 1'b1; e = cyc + 1;
    push_first_seg(e, "first_seg");
    step(1); start = 1'b0;
    step(10000);
    push(cyc + 1, "surv_score", 3'b000, 1'b0, 1'b0, 16'((cyc + 1 - e) / 2), 1'b0, 1'b0);
    step(2);

    // Lower death boundary
    height = 9'd10;
    push(cyc + 4, "alive_at_10", 3'b000, 1'b0, 1'b0, 16'((cyc + 4 - e) / 2), 1'b0, 1'b0);
    step(4);
    height = 9'd9; v = cyc;
    push(v + 1, "dead_at_9", 3'b000, 1'b1, 1'b1, 16'((v - e) / 2), 1'b0, 1'b1);
    push(v + 4, "dead_hold", 3'b000, 1'b1, 1'b1, 16'((v - e) / 2), 1'b0, 1'b1);
    step(1); height = 9'd200;
    step(4);

    // Restart, upper death boundary
    start = 1'b1; e = cyc + 1;
    push(e, "restart", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1); start = 1'b0; height = 9'd470;
    push(e + 6, "alive_at_470", 3'b111, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1);
    step(6);
    height = 9'd471;
    push(cyc + 1, "dead_at_471", 3'b000, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1);
    push(cyc + 3, "dead_471_hold", 3'b000, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1);
    step(1); height = 9'd200;
    step(3);

    // Restart with continuing LFSR (first segment checked by the monitor model), then mid-run reset
    start = 1'b1; e = cyc + 1;
    push(e, "restart2", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1); start = 1'b0;
    step(20);
    rst = 1'b1;
    push(cyc + 1, "midrun_rst", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1); rst = 1'b0;
    push(cyc + 2, "idle_after_rst", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(3);

    // After reset the LFSR is back at SEED: same first segment as before
    start = 1'b1; e = cyc + 1;
    push_first_seg(e, "reseed_seg");
    step(1); start = 1'b0;
    step(60);
    height = 9'd471;
    push(cyc + 1, "dead_after_seg2", 3'b000, 1'b1, 1'b1, 16'd30, 1'b0, 1'b1);
    step(1); height = 9'd200;
    step(2);

    // Death on the same clock as the segment-boundary tick
    start = 1'b1; e = cyc + 1;
    push(e, "restart3", 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1); start = 1'b0;
    step(15);
    height = 9'd471;
    push(e + 16, "dead_on_boundary", 3'b000, 1'b1, 1'b1, 16'd7, 1'b0, 1'b1);
    push(e + 18, "dead_boundary_hold", 3'b000, 1'b1, 1'b1, 16'd7, 1'b0, 1'b1);
    step(1); height = 9'd200;
    step(3);

    // Score saturation on the one-tick-per-clock instance
    g = 0;
    while (score2 != 16'hFFFE && g < 70000) begin
      @(negedge clk);
      g++;
    end
    chk("sat_reach_fffe", score2 == 16'hFFFE, $sformatf("score=%h req fffe after %0d clk", score2, g));
    step(3);
    chk("sat_fffff", score2 == 16'hFFFF && is_dead2 == 1'b0 && lines2 != 3'b000,
        $sformatf("score=%h req ffff dead=%b lines=%b seg=%b", score2, is_dead2, lines2, seg_start2));
    step(5);
    chk("sat_hold", score2 == 16'hFFFF, $sformatf("score=%h req ffff", score2));

    step(2);
    chk("sb_drained", sb.size() == 0, $sformatf("pending=%0d req 0", sb.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
